// File: rtl/mac_pkg.sv
// Shared types and arithmetic helpers for the pipelined multiply-accumulate PE.
package mac_pkg;

  typedef enum logic {
    MAC_WRAP = 1'b0,
    MAC_SAT  = 1'b1
  } mac_mode_e;

  // Helpers evaluate at this width; the top checks that every operand fits with headroom.
  localparam int SAT_W = 64;

  // Exact width of a LANES-wide sum of signed bits_ab x bits_ab products.
  function automatic int prod_width(input int bits_ab, input int lanes);
    return 2 * bits_ab + $clog2(lanes);
  endfunction

  // Adds two sign-extended operands exactly, flags an out-of-range result for a
  // bits_c-wide accumulator, then clamps or wraps it according to mode.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input  logic signed [SAT_W-1:0] a,
    input  logic signed [SAT_W-1:0] b,
    input  int                      bits_c,
    input  mac_mode_e               mode,
    output logic                    ovf
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (bits_c - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (bits_c - 1));
    ovf = (sum > hi) || (sum < lo);
    if (mode == MAC_WRAP)
      sat_add = (sum <<< (SAT_W - bits_c)) >>> (SAT_W - bits_c);
    else if (sum > hi)
      sat_add = hi;
    else if (sum < lo)
      sat_add = lo;
    else
      sat_add = sum;
  endfunction

endpackage

// File: rtl/mac_pe_if.sv
// Operand/result bundle of one systolic MAC cell.
// Handshake: en launches a product (no backpressure); busy is the product-valid
// flag, meaning a product is registered and accumulates on the next edge.
interface mac_pe_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int LANES   = 2
);
  logic                     WrEn;
  logic                     en;
  logic                     clr;
  logic [LANES*BITS_AB-1:0] Ain;
  logic [LANES*BITS_AB-1:0] Bin;
  logic [BITS_C-1:0]        Cin;
  logic [LANES*BITS_AB-1:0] Aout;
  logic [LANES*BITS_AB-1:0] Bout;
  logic [BITS_C-1:0]        Cout;
  logic                     busy;
  logic                     ovf;

  modport master (
    output WrEn, en, clr, Ain, Bin, Cin,
    input  Aout, Bout, Cout, busy, ovf
  );

  modport slave (
    input  WrEn, en, clr, Ain, Bin, Cin,
    output Aout, Bout, Cout, busy, ovf
  );
endinterface

// File: rtl/mac_dot_stage.sv
// Stage 1: registers the forwarded operands and the exact LANES-wide dot product.
module mac_dot_stage #(
  parameter int BITS_AB = 8,
  parameter int LANES   = 2,
  parameter int PW      = 2 * BITS_AB + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       squash,
  input  logic [LANES*BITS_AB-1:0]   ain,
  input  logic [LANES*BITS_AB-1:0]   bin,
  output logic [LANES*BITS_AB-1:0]   aout,
  output logic [LANES*BITS_AB-1:0]   bout,
  output logic signed [PW-1:0]       prod,
  output logic                       busy
);

  logic signed [PW-1:0] prod_d;

  // Lanes are widened to PW before multiplying so no product or partial sum truncates.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      logic signed [BITS_AB-1:0] a_l;
      logic signed [BITS_AB-1:0] b_l;
      a_l    = signed'(ain[i*BITS_AB +: BITS_AB]);
      b_l    = signed'(bin[i*BITS_AB +: BITS_AB]);
      prod_d = prod_d + (PW'(a_l) * PW'(b_l));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aout <= '0;
      bout <= '0;
      prod <= '0;
      busy <= 1'b0;
    end else if (en && !squash) begin
      aout <= ain;
      bout <= bin;
      prod <= prod_d;
      busy <= 1'b1;
    end else begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mac_pe.sv
// Pipelined multiply-accumulate PE: dot-product stage feeding a wrap/saturate
// accumulator with preload, synchronous clear and sticky overflow.
module mac_pe
  import mac_pkg::*;
#(
  parameter int        BITS_AB = 8,
  parameter int        BITS_C  = 16,
  parameter int        LANES   = 2,
  parameter mac_mode_e MODE    = MAC_SAT
) (
  input logic     clk,
  input logic     rst_n,
  mac_pe_if.slave bus
);

  localparam int PW   = prod_width(BITS_AB, LANES);
  localparam int SUMW = ((BITS_C > PW) ? BITS_C : PW) + 1;

  if (LANES < 1) begin : g_bad_lanes
    $error("mac_pe: LANES must be at least 1");
  end
  if (BITS_C < BITS_AB) begin : g_bad_bits_c
    $error("mac_pe: BITS_C must be at least BITS_AB");
  end
  if (SUMW >= SAT_W) begin : g_bad_sum_width
    $error("mac_pe: accumulator sum does not fit the helper width");
  end

  logic [LANES*BITS_AB-1:0] aout;
  logic [LANES*BITS_AB-1:0] bout;
  logic signed [PW-1:0]     prod;
  logic                     busy;

  mac_dot_stage #(
    .BITS_AB (BITS_AB),
    .LANES   (LANES),
    .PW      (PW)
  ) u_dot (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (bus.en),
    .squash (bus.WrEn),
    .ain    (bus.Ain),
    .bin    (bus.Bin),
    .aout   (aout),
    .bout   (bout),
    .prod   (prod),
    .busy   (busy)
  );

  logic signed [BITS_C-1:0] cout_q;
  logic                     ovf_q;
  logic signed [SAT_W-1:0]  acc_x;
  logic signed [SAT_W-1:0]  prod_x;
  logic signed [SAT_W-1:0]  sum_x;
  logic                     sum_ovf;

  // Sign-extended wide add is exact for any legal parameter set (checked above).
  always_comb begin
    sum_ovf = 1'b0;
    acc_x   = SAT_W'(cout_q);
    prod_x  = SAT_W'(prod);
    sum_x   = sat_add(acc_x, prod_x, BITS_C, MODE, sum_ovf);
  end

  // Preload beats clear beats accumulate; preload and clear also drop a pending product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (bus.WrEn) begin
      cout_q <= bus.Cin;
      ovf_q  <= 1'b0;
    end else if (bus.clr) begin
      cout_q <= '0;
      ovf_q  <= 1'b0;
    end else if (busy) begin
      cout_q <= sum_x[BITS_C-1:0];
      if (sum_ovf) ovf_q <= 1'b1;
    end
  end

  assign bus.Aout = aout;
  assign bus.Bout = bout;
  assign bus.Cout = cout_q;
  assign bus.busy = busy;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed bench for mac_pe: a saturating and a wrapping instance share one stimulus stream.
module tb_mac_pe;
  import mac_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  mac_pe_if #(.BITS_AB(8), .BITS_C(16), .LANES(2)) s_if ();
  mac_pe_if #(.BITS_AB(8), .BITS_C(16), .LANES(2)) w_if ();

  assign w_if.WrEn = s_if.WrEn;
  assign w_if.en   = s_if.en;
  assign w_if.clr  = s_if.clr;
  assign w_if.Ain  = s_if.Ain;
  assign w_if.Bin  = s_if.Bin;
  assign w_if.Cin  = s_if.Cin;

  mac_pe #(.BITS_AB(8), .BITS_C(16), .LANES(2), .MODE(MAC_SAT)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  mac_pe #(.BITS_AB(8), .BITS_C(16), .LANES(2), .MODE(MAC_WRAP)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_if.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timed out");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic e, input logic c,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] cin);
    s_if.WrEn = wr;
    s_if.en   = e;
    s_if.clr  = c;
    s_if.Ain  = a;
    s_if.Bin  = b;
    s_if.Cin  = cin;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_aout"}, s_if.Aout, 16'h0000);
    chk({tag, "_bout"}, s_if.Bout, 16'h0000);
    chk({tag, "_cout_s"}, s_if.Cout, 16'h0000);
    chk({tag, "_cout_w"}, w_if.Cout, 16'h0000);
    chk({tag, "_busy"}, 16'(s_if.busy), 16'h0000);
    chk({tag, "_ovf_s"}, 16'(s_if.ovf), 16'h0000);
    chk({tag, "_ovf_w"}, 16'(w_if.ovf), 16'h0000);
  endtask

  // A = {3,4}, B = {5,-2}: dot product 15 - 8 = 7
  localparam logic [15:0] A_34  = 16'h0403;
  localparam logic [15:0] B_5M2 = 16'hFE05;
  localparam logic [15:0] V_MAX = 16'h7F7F;
  localparam logic [15:0] V_MIN = 16'h8080;

  initial begin
    // reset with random inputs
    rst_n = 1'b0;
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          16'($urandom), 16'($urandom), 16'($urandom));
    step();
    step();
    chk_zero("reset");
    drive(1'b0, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
    rst_n = 1'b1;
    step();
    step();
    chk_zero("post_release");

    // basic accumulate
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd100);
    step();
    chk("preload_100", s_if.Cout, 16'd100);
    drive(1'b0, 1'b1, 1'b0, A_34, B_5M2, 16'h0000);
    step();
    chk("basic_aout", s_if.Aout, A_34);
    chk("basic_bout", s_if.Bout, B_5M2);
    chk("basic_busy", 16'(s_if.busy), 16'h0001);
    chk("basic_cout_hold", s_if.Cout, 16'd100);
    step();
    chk("basic_107", s_if.Cout, 16'd107);
    chk("basic_busy_stream", 16'(s_if.busy), 16'h0001);
    drive(1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h0000);
    step();
    chk("basic_114", s_if.Cout, 16'd114);
    chk("basic_114_wrap", w_if.Cout, 16'd114);
    chk("basic_busy_drain", 16'(s_if.busy), 16'h0000);
    chk("basic_ovf", 16'(s_if.ovf), 16'h0000);
    chk("basic_aout_hold", s_if.Aout, A_34);

    // positive overflow: 32700 + 32258 = 64958
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd32700);
    step();
    drive(1'b0, 1'b1, 1'b0, V_MAX, V_MAX, 16'h0000);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("posovf_sat", s_if.Cout, 16'h7FFF);
    chk("posovf_sat_flag", 16'(s_if.ovf), 16'h0001);
    chk("posovf_wrap", w_if.Cout, 16'hFDBE);
    chk("posovf_wrap_flag", 16'(w_if.ovf), 16'h0001);
    step();
    chk("posovf_sticky", 16'(s_if.ovf), 16'h0001);
    chk("posovf_idle_hold", s_if.Cout, 16'h7FFF);

    // negative saturation: -32768 + (-32512) = -65280
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h8000);
    step();
    chk("negsat_preload_ovf_clear", 16'(s_if.ovf), 16'h0000);
    drive(1'b0, 1'b1, 1'b0, V_MIN, V_MAX, 16'h0000);
    step();
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("negsat_sat", s_if.Cout, 16'h8000);
    chk("negsat_sat_flag", 16'(s_if.ovf), 16'h0001);
    chk("negsat_wrap", w_if.Cout, 16'h0100);
    chk("negsat_wrap_flag", 16'(w_if.ovf), 16'h0001);
    drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("clr_cout", s_if.Cout, 16'h0000);
    chk("clr_ovf", 16'(s_if.ovf), 16'h0000);
    chk("clr_ovf_w", 16'(w_if.ovf), 16'h0000);

    // squash: en then WrEn on the next cycle
    drive(1'b0, 1'b1, 1'b0, A_34, B_5M2, 16'h0000);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd5);
    step();
    chk("squash_cout", s_if.Cout, 16'd5);
    chk("squash_busy", 16'(s_if.busy), 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("squash_lost", s_if.Cout, 16'd5);

    // WrEn + clr + en together: preload wins, operands not captured
    drive(1'b1, 1'b1, 1'b1, 16'h0102, 16'h0304, 16'hFFF9);
    step();
    chk("all_cout", s_if.Cout, 16'hFFF9);
    chk("all_aout", s_if.Aout, A_34);
    chk("all_busy", 16'(s_if.busy), 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("all_hold", s_if.Cout, 16'hFFF9);

    // clr with en: product captured, lands on a cleared accumulator
    drive(1'b0, 1'b1, 1'b1, A_34, B_5M2, 16'h0000);
    step();
    chk("clr_en_cout", s_if.Cout, 16'h0000);
    chk("clr_en_busy", 16'(s_if.busy), 16'h0001);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("clr_en_acc", s_if.Cout, 16'd7);

    // mid-operation reset while streaming
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'd1000);
    step();
    drive(1'b0, 1'b1, 1'b0, V_MAX, V_MAX, 16'h0000);
    step();
    step();
    chk("midrst_busy_before", 16'(s_if.busy), 16'h0001);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    drive(1'b0, 1'b0, 1'b0, 16'h0101, 16'h0202, 16'h0000);
    #3;
    rst_n = 1'b1;
    step();
    chk("midrst_no_stale", s_if.Cout, 16'h0000);
    chk("midrst_busy_after", 16'(s_if.busy), 16'h0000);
    drive(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0202, 16'h0000);
    step();
    chk("midrst_new_busy", 16'(s_if.busy), 16'h0001);
    chk("midrst_new_hold", s_if.Cout, 16'h0000);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
    step();
    chk("midrst_new_acc", s_if.Cout, 16'd4);

    // report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
